// File: rtl/sweep_tone_gen.sv
// Swept square-wave tone generator: half-period walks between lo/hi bounds in
// up-wrap, down-wrap, ping-pong or one-shot mode. Define SWEEP_VOLUME_EN for 4-bit PWM volume gating.
module sweep_tone_gen #(
  parameter int HP_W   = 24,
  parameter int RATE_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [HP_W-1:0]   i_lo,
  input  logic [HP_W-1:0]   i_hi,
  input  logic [HP_W-1:0]   i_step,
  input  logic [RATE_W-1:0] i_rate,
`ifdef SWEEP_VOLUME_EN
  input  logic [3:0]        i_vol,
`endif
  output logic              o_pulse,
  output logic              o_busy,
  output logic              o_done,
  output logic [HP_W-1:0]   o_cur
);

  localparam logic [HP_W-1:0]   ONE_HP   = {{(HP_W-1){1'b0}}, 1'b1};
  localparam logic [RATE_W-1:0] ONE_RATE = {{(RATE_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [HP_W-1:0] cur;
    logic            dir;
    logic            fin;
  } sweep_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_r, mode_nxt;
  logic [HP_W-1:0]   lo_r, lo_nxt, hi_r, hi_nxt, step_r, step_nxt;
  logic [RATE_W-1:0] rate_r, rate_nxt;
  logic [HP_W-1:0]   cur, cur_nxt, tcnt, tcnt_nxt;
  logic [RATE_W-1:0] rcnt, rcnt_nxt;
  logic              dir, dir_nxt, fin, fin_nxt;
  logic              square, square_nxt, done, done_nxt;
  logic              accept;
  sweep_t            sw;
`ifdef SWEEP_VOLUME_EN
  logic [3:0]        vol_r, vol_nxt, slot, slot_nxt;
`endif

  // One sweep tick; bound tests use HP_W+1 bits so cur+step never wraps silently.
  function automatic sweep_t sweep_apply(input logic [1:0] m, input logic [HP_W-1:0] c,
                                         input logic [HP_W-1:0] lo, input logic [HP_W-1:0] hi,
                                         input logic [HP_W-1:0] st, input logic d);
    logic [HP_W:0] up, floor_v;
    sweep_t r;
    up      = {1'b0, c} + {1'b0, st};
    floor_v = {1'b0, lo} + {1'b0, st};
    r.cur = c;
    r.dir = d;
    r.fin = 1'b0;
    case (m)
      2'b00: r.cur = (up > {1'b0, hi}) ? lo : up[HP_W-1:0];
      2'b01: r.cur = ({1'b0, c} < floor_v) ? hi : c - st;
      2'b10: begin
        if (!d) begin
          if (up > {1'b0, hi}) begin
            r.cur = hi;
            r.dir = 1'b1;
          end else begin
            r.cur = up[HP_W-1:0];
          end
        end else begin
          if ({1'b0, c} < floor_v) begin
            r.cur = lo;
            r.dir = 1'b0;
          end else begin
            r.cur = c - st;
          end
        end
      end
      default: begin
        if (up > {1'b0, hi}) begin
          r.cur = hi;
          r.fin = 1'b1;
        end else begin
          r.cur = up[HP_W-1:0];
        end
      end
    endcase
    return r;
  endfunction

  assign accept = i_start && (i_lo <= i_hi) && (i_rate != '0);

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_r;
    lo_nxt     = lo_r;
    hi_nxt     = hi_r;
    step_nxt   = step_r;
    rate_nxt   = rate_r;
    cur_nxt    = cur;
    tcnt_nxt   = tcnt;
    rcnt_nxt   = rcnt;
    dir_nxt    = dir;
    fin_nxt    = fin;
    square_nxt = square;
    done_nxt   = 1'b0;
    sw         = '0;
`ifdef SWEEP_VOLUME_EN
    vol_nxt    = vol_r;
    slot_nxt   = slot + 4'd1;
`endif
    if (i_stop) begin
      state_nxt  = IDLE;
      square_nxt = 1'b0;
      fin_nxt    = 1'b0;
    end else if (accept) begin
      state_nxt  = RUN;
      mode_nxt   = i_mode;
      lo_nxt     = i_lo;
      hi_nxt     = i_hi;
      step_nxt   = i_step;
      rate_nxt   = i_rate;
      cur_nxt    = (i_mode == 2'b01) ? i_hi : i_lo;
      dir_nxt    = (i_mode == 2'b01);
      tcnt_nxt   = '0;
      rcnt_nxt   = '0;
      fin_nxt    = 1'b0;
      square_nxt = 1'b0;
`ifdef SWEEP_VOLUME_EN
      vol_nxt    = i_vol;
      slot_nxt   = 4'd0;
`endif
    end else if (state == RUN) begin
      if (fin) begin
        // One-shot reached hi on the previous tick.
        state_nxt  = IDLE;
        done_nxt   = 1'b1;
        square_nxt = 1'b0;
        fin_nxt    = 1'b0;
      end else begin
        if (cur == '0) begin
          square_nxt = 1'b0;
          tcnt_nxt   = '0;
        end else if (tcnt >= cur - ONE_HP) begin
          square_nxt = ~square;
          tcnt_nxt   = '0;
        end else begin
          tcnt_nxt   = tcnt + ONE_HP;
        end
        if (rcnt == rate_r - ONE_RATE) begin
          rcnt_nxt = '0;
          sw       = sweep_apply(mode_r, cur, lo_r, hi_r, step_r, dir);
          cur_nxt  = sw.cur;
          dir_nxt  = sw.dir;
          fin_nxt  = sw.fin;
        end else begin
          rcnt_nxt = rcnt + ONE_RATE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      mode_r <= '0;
      lo_r   <= '0;
      hi_r   <= '0;
      step_r <= '0;
      rate_r <= '0;
      cur    <= '0;
      tcnt   <= '0;
      rcnt   <= '0;
      dir    <= 1'b0;
      fin    <= 1'b0;
      square <= 1'b0;
      done   <= 1'b0;
`ifdef SWEEP_VOLUME_EN
      vol_r  <= '0;
      slot   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      mode_r <= mode_nxt;
      lo_r   <= lo_nxt;
      hi_r   <= hi_nxt;
      step_r <= step_nxt;
      rate_r <= rate_nxt;
      cur    <= cur_nxt;
      tcnt   <= tcnt_nxt;
      rcnt   <= rcnt_nxt;
      dir    <= dir_nxt;
      fin    <= fin_nxt;
      square <= square_nxt;
      done   <= done_nxt;
`ifdef SWEEP_VOLUME_EN
      vol_r  <= vol_nxt;
      slot   <= slot_nxt;
`endif
    end
  end

  assign o_busy = (state == RUN);
  assign o_done = done;
  assign o_cur  = cur;
`ifdef SWEEP_VOLUME_EN
  assign o_pulse = square & (slot < vol_r);
`else
  assign o_pulse = square;
`endif

endmodule

// File: tb/tb_sweep_tone_gen.sv
// Bench for sweep_tone_gen: fixed sweep-sequence table, hand-written corner
// sequences, and randomized traffic against a cycle-level behavioural model.
module tb_sweep_tone_gen;

  localparam int HP_W   = 8;
  localparam int RATE_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop;
  logic [1:0]        mode;
  logic [HP_W-1:0]   lo, hi, step;
  logic [RATE_W-1:0] rate;
  logic [3:0]        vol;
  logic              pulse, busy, done;
  logic [HP_W-1:0]   cur;

  sweep_tone_gen #(.HP_W(HP_W), .RATE_W(RATE_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_stop  (stop),
    .i_mode  (mode),
    .i_lo    (lo),
    .i_hi    (hi),
    .i_step  (step),
    .i_rate  (rate),
`ifdef SWEEP_VOLUME_EN
    .i_vol   (vol),
`endif
    .o_pulse (pulse),
    .o_busy  (busy),
    .o_done  (done),
    .o_cur   (cur)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  int m_run, m_cur, m_sq, m_since, m_age, m_dir, m_fin, m_done, m_slot;
  int c_mode, c_lo, c_hi, c_step, c_rate, c_vol;

  typedef struct {
    logic [1:0] mode;
    int lo, hi, step, rate, n;
    int seq[6];
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_cur = 0; m_sq = 0; m_since = 0; m_age = 0;
    m_dir = 0; m_fin = 0; m_done = 0; m_slot = 0;
    c_mode = 0; c_lo = 0; c_hi = 0; c_step = 0; c_rate = 0; c_vol = 0;
  endtask

  task automatic model_step();
    int old;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    m_slot = (m_slot + 1) % 16;
    if (stop) begin
      m_run = 0; m_sq = 0; m_fin = 0;
    end else if (start && int'(lo) <= int'(hi) && rate != 0) begin
      c_mode = int'(mode); c_lo = int'(lo); c_hi = int'(hi);
      c_step = int'(step); c_rate = int'(rate); c_vol = int'(vol);
      m_run = 1; m_cur = (c_mode == 1) ? c_hi : c_lo;
      m_sq = 0; m_since = 0; m_age = 0; m_fin = 0; m_slot = 0;
      m_dir = (c_mode == 1) ? 1 : 0;
    end else if (m_run == 1) begin
      if (m_fin == 1) begin
        m_run = 0; m_done = 1; m_sq = 0; m_fin = 0;
      end else begin
        old = m_cur;
        if (old == 0) begin
          m_sq = 0; m_since = 0;
        end else if (m_since + 1 >= old) begin
          m_sq = 1 - m_sq; m_since = 0;
        end else begin
          m_since++;
        end
        m_age++;
        if (m_age % c_rate == 0) begin
          case (c_mode)
            0: m_cur = (old + c_step > c_hi) ? c_lo : old + c_step;
            1: m_cur = (old - c_step < c_lo) ? c_hi : old - c_step;
            2: begin
              if (m_dir == 0) begin
                if (old + c_step > c_hi) begin m_cur = c_hi; m_dir = 1; end
                else m_cur = old + c_step;
              end else begin
                if (old - c_step < c_lo) begin m_cur = c_lo; m_dir = 0; end
                else m_cur = old - c_step;
              end
            end
            default: begin
              if (old + c_step > c_hi) begin m_cur = c_hi; m_fin = 1; end
              else m_cur = old + c_step;
            end
          endcase
        end
      end
    end
  endtask

  function automatic int exp_pulse();
`ifdef SWEEP_VOLUME_EN
    return (m_sq == 1 && m_slot < c_vol) ? 1 : 0;
`else
    return m_sq;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("busy", int'(busy), m_run);
    check("cur", int'(cur), m_cur);
    check("pulse", int'(pulse), exp_pulse());
    check("done", int'(done), m_done);
  endtask

  task automatic add_vec(input logic [1:0] m, input int l, input int h, input int s, input int r,
                         input int n, input int s0, input int s1, input int s2,
                         input int s3, input int s4, input int s5);
    vec_t v;
    v.mode = m; v.lo = l; v.hi = h; v.step = s; v.rate = r; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
    v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
    vecs.push_back(v);
  endtask

  task automatic set_cfg(input int m, input int l, input int h, input int s, input int r);
    mode = 2'(m); lo = HP_W'(l); hi = HP_W'(h); step = HP_W'(s); rate = RATE_W'(r);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; vol = 4'd15;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();

    add_vec(2'd0,   4,  10,  3, 20, 5,   4,   7,  10,   4,   7, 0);
    add_vec(2'd2,   2,   8,  4,  5, 6,   2,   6,   8,   4,   2, 6);
    add_vec(2'd1,   3,   9,  4,  3, 4,   9,   5,   9,   5,   0, 0);
    add_vec(2'd0, 240, 255, 10,  2, 4, 240, 250, 240, 250,   0, 0);
    add_vec(2'd0,   7,   7,  3,  2, 3,   7,   7,   7,   0,   0, 0);
    add_vec(2'd2, 250, 255,  4,  2, 5, 250, 254, 255, 251, 250, 0);

    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_cur", int'(cur), 0);
    check("reset_pulse", int'(pulse), 0);
    check("reset_done", int'(done), 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Table-driven sweep sequences
    foreach (vecs[i]) begin
      set_cfg(int'(vecs[i].mode), vecs[i].lo, vecs[i].hi, vecs[i].step, vecs[i].rate);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("tbl_cur", int'(cur), vecs[i].seq[0]);
      for (int k = 1; k < vecs[i].n; k++) begin
        repeat (vecs[i].rate) cycle();
        check("tbl_cur", int'(cur), vecs[i].seq[k]);
      end
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      check("tbl_stop_busy", int'(busy), 0);
    end

    // One-shot completion
    set_cfg(3, 5, 12, 5, 3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("os_cur0", int'(cur), 5);
    repeat (3) cycle();
    check("os_cur1", int'(cur), 10);
    repeat (3) cycle();
    check("os_cur2", int'(cur), 12);
    check("os_busy", int'(busy), 1);
    check("os_done_early", int'(done), 0);
    cycle();
    check("os_done", int'(done), 1);
    check("os_busy_fall", int'(busy), 0);
    check("os_pulse", int'(pulse), 0);
    cycle();
    check("os_done_once", int'(done), 0);

    // Rejected starts
    set_cfg(0, 9, 3, 1, 5);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("bad_lohi_busy", int'(busy), 0);
    set_cfg(0, 1, 3, 1, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("bad_rate_busy", int'(busy), 0);

    // Start and stop together during RUN: stop wins, cur held
    set_cfg(0, 4, 10, 3, 20);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (25) cycle();
    check("run_cur", int'(cur), 7);
    set_cfg(0, 1, 2, 1, 1);
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", int'(busy), 0);
    check("startstop_cur", int'(cur), 7);

    // Asynchronous reset mid-sweep
    set_cfg(0, 4, 10, 3, 20);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", int'(busy), 0);
    check("areset_cur", int'(cur), 0);
    check("areset_pulse", int'(pulse), 0);
    check("areset_done", int'(done), 0);
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    check("post_reset_busy", int'(busy), 0);

`ifdef SWEEP_VOLUME_EN
    // Zero volume silences the tone entirely
    set_cfg(0, 3, 3, 0, 1);
    vol = 4'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      check("vol0_pulse", int'(pulse), 0);
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    vol = 4'd8;
    set_cfg(0, 40, 40, 0, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (150) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start = 1'b0;
      stop  = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 24)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 5)));
        vol = 4'($urandom_range(0, 15));
        start = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) stop = 1'b1;
      cycle();
    end
    start = 1'b0;
    stop  = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
